// File: rtl/parallel_hps_single_pio_word_packer.sv
// Byte-to-word packer for a 32-bit input PIO.
// Bytes are collected into up to three payload slots. A completed word is
// published on out_port together with a toggle bit, a last flag, a byte count
// and a 4-bit sequence number. The word then stays stable for HOLD_CYCLES
// cycles, during which in_ready is low. The toggle bit makes every publish
// visible to an edge-detecting PIO, even when the payloads are identical.
module parallel_hps_single_pio_word_packer #(
   parameter int unsigned HOLD_CYCLES = 4   // legal range 2..255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   input  logic        in_last,
   output logic        in_ready,
   output logic [31:0] out_port,
   output logic [15:0] word_count
);

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic        r_in_ready;
   logic [1:0]  r_slot;
   logic [15:0] r_buf;         // bytes 0 and 1 of the word being filled
   logic [3:0]  r_seq;
   logic [7:0]  r_hold_cnt;
   logic [31:0] r_out;
   logic [15:0] r_word_count;

   logic        w_accept;
   logic        w_complete;
   logic        w_hold_done;
   logic        w_ready_next;
   logic [1:0]  w_count;
   logic [23:0] w_payload;

   // A byte is taken only while the registered ready is high; the word closes on slot 2 or on in_last.
   assign w_accept    = in_valid & r_in_ready & (r_state == ST_FILL);
   assign w_complete  = w_accept & ((r_slot == 2'd2) | in_last);
   assign w_hold_done = (r_state == ST_HOLD) && (r_hold_cnt == 8'(HOLD_CYCLES - 1));

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_FILL;
      end else begin
         // NOTE: sequential state is always updated with <= so that every flop samples pre-edge values.
         r_state <= w_state_next;
      end
   end

   // Next-state logic: FILL until a word completes, HOLD until the hold counter expires.
   always_comb begin
      // NOTE: a default assignment comes first, so every path drives the signal and no latch is inferred.
      w_state_next = r_state;
      case (r_state)
         ST_FILL: if (w_complete)  w_state_next = ST_HOLD;
         ST_HOLD: if (w_hold_done) w_state_next = ST_FILL;
         default:                  w_state_next = ST_FILL;
      endcase
   end

   // Output decode: next value of the ready flop and the word assembled from the completing byte.
   always_comb begin
      w_ready_next = (w_state_next == ST_FILL);
      w_count      = r_slot + 2'd1;
      w_payload    = '0;
      case (r_slot)
         2'd0:    w_payload = {16'h0000, in_data};
         2'd1:    w_payload = {8'h00, in_data, r_buf[7:0]};
         default: w_payload = {in_data, r_buf};
      endcase
   end

   // Datapath: ready flop, hold counter, slot/buffer fill and word publication.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_in_ready   <= 1'b0;
         r_hold_cnt   <= '0;
         r_slot       <= '0;
         r_buf        <= '0;
         r_seq        <= '0;
         r_out        <= '0;
         r_word_count <= '0;
      end else begin
         r_in_ready <= w_ready_next;

         if (r_state == ST_HOLD && !w_hold_done) begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
         end else begin
            r_hold_cnt <= '0;
         end

         if (w_complete) begin
            r_out        <= {~r_out[31], in_last, w_count, r_seq, w_payload};
            r_seq        <= r_seq + 4'd1;
            r_word_count <= r_word_count + 16'd1;
            r_slot       <= '0;
            r_buf        <= '0;
         end else if (w_accept) begin
            r_slot <= r_slot + 2'd1;
            if (r_slot == 2'd0) begin
               r_buf[7:0] <= in_data;
            end else begin
               r_buf[15:8] <= in_data;
            end
         end
      end
   end

   assign in_ready   = r_in_ready;
   assign out_port   = r_out;
   assign word_count = r_word_count;

endmodule

// File: tb/tb_parallel_hps_single_pio_word_packer.sv
// Self-checking bench for parallel_hps_single_pio_word_packer.
// A queue-based model predicts published words and the ready window. The
// model and a table of fixed vectors are both compared against the DUT.
module tb_parallel_hps_single_pio_word_packer;

   localparam int HOLD = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic        in_ready;
   logic [31:0] out_port;
   logic [15:0] word_count;

   int n_cmp = 0;
   int n_bad = 0;

   parallel_hps_single_pio_word_packer #(.HOLD_CYCLES(HOLD)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .out_port   (out_port),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   // Reference model state.
   logic [7:0]  m_bytes[$];
   logic        m_ready;
   int          m_hold_left;
   logic        m_tog;
   int          m_seq;
   int          m_wc;
   logic [31:0] m_out;
   logic        m_acc;

   logic [31:0] prev_out;
   int          changes;

   typedef struct {
      logic [7:0]  data;
      logic        last;
      logic [31:0] exp_out;
      logic [15:0] exp_wc;
   } vec_t;

   vec_t tbl[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_bytes.delete();
      m_ready     = 1'b0;
      m_hold_left = 0;
      m_tog       = 1'b0;
      m_seq       = 0;
      m_wc        = 0;
      m_out       = '0;
      m_acc       = 1'b0;
      prev_out    = '0;
   endtask

   // Applies one clock edge to the model, using the inputs driven before that edge.
   task automatic model_edge(input logic v, input logic [7:0] d, input logic l);
      logic [23:0] pay;
      m_acc = v && m_ready;
      if (m_hold_left > 0) begin
         m_hold_left--;
         if (m_hold_left == 0) m_ready = 1'b1;
      end else begin
         m_ready = 1'b1;
      end
      if (m_acc) begin
         m_bytes.push_back(d);
         if (m_bytes.size() == 3 || l) begin
            pay = '0;
            foreach (m_bytes[i]) pay = pay | (24'(m_bytes[i]) << (8 * i));
            m_tog = ~m_tog;
            m_out = {m_tog, l, 2'(m_bytes.size()), 4'(m_seq), pay};
            m_seq = (m_seq + 1) % 16;
            m_wc  = (m_wc + 1) % 65536;
            m_bytes.delete();
            m_ready     = 1'b0;
            m_hold_left = HOLD;
         end
      end
   endtask

   // Drives one cycle, advances the model and compares all outputs.
   task automatic step(input logic v, input logic [7:0] d, input logic l);
      in_valid = v;
      in_data  = d;
      in_last  = l;
      @(posedge clk);
      #1;
      model_edge(v, d, l);
      check("out_port", out_port, m_out);
      check("word_count", {16'h0, word_count}, 32'(m_wc));
      check("in_ready", {31'h0, in_ready}, {31'h0, m_ready});
      if (out_port !== prev_out) changes++;
      prev_out = out_port;
   endtask

   // Holds a byte on the bus until it is accepted; waits = cycles it was refused.
   task automatic send(input logic [7:0] d, input logic l, output int waits);
      bit done;
      done  = 1'b0;
      waits = 0;
      while (!done && waits < 64) begin
         step(1'b1, d, l);
         if (m_acc) done = 1'b1;
         else waits++;
      end
      in_valid = 1'b0;
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: byte %h not accepted within 64 cycles", d);
      end
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      #1;
      check("rst_out_port", out_port, 32'h0);
      check("rst_in_ready", {31'h0, in_ready}, 32'h0);
      check("rst_word_count", {16'h0, word_count}, 32'h0);
      @(posedge clk);
      #1;
      check("rst_hold_out_port", out_port, 32'h0);
      check("rst_hold_in_ready", {31'h0, in_ready}, 32'h0);
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      int w;
      logic [31:0] saved;
      logic [7:0]  p_d;
      logic        p_v;
      logic        p_l;

      tbl[0] = '{8'h11, 1'b0, 32'h0000_0000, 16'd0};
      tbl[1] = '{8'h22, 1'b0, 32'h0000_0000, 16'd0};
      tbl[2] = '{8'h33, 1'b0, 32'hB033_2211, 16'd1};
      tbl[3] = '{8'h44, 1'b1, 32'h5100_0044, 16'd2};
      tbl[4] = '{8'hAA, 1'b1, 32'hD200_00AA, 16'd3};
      tbl[5] = '{8'h01, 1'b0, 32'hD200_00AA, 16'd3};

      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      // Fixed vectors: first full word, single-byte flush, and a partial word.
      foreach (tbl[i]) begin
         send(tbl[i].data, tbl[i].last, w);
         check($sformatf("tbl_out_%0d", i), out_port, tbl[i].exp_out);
         check($sformatf("tbl_wc_%0d", i), {16'h0, word_count}, {16'h0, tbl[i].exp_wc});
      end
      send(8'h02, 1'b1, w);
      check("tbl_two_byte_word", out_port, 32'h6300_0201);

      // Valid held high continuously: the refusal window after each word must be HOLD cycles.
      do_reset();
      for (int i = 0; i < 12; i++) begin
         send(8'(8'h40 + i), 1'b0, w);
         if (i > 0) check($sformatf("hold_wait_%0d", i), 32'(w), (i % 3 == 0) ? 32'(HOLD) : 32'h0);
      end

      // Seventeen identical words: the sequence field wraps and every publish changes out_port.
      do_reset();
      changes = 0;
      for (int i = 0; i < 17 * 3; i++) send(8'h00, 1'b0, w);
      check("wrap_changes", 32'(changes), 32'd17);
      check("wrap_word17", out_port, 32'hB000_0000);
      check("wrap_wc", {16'h0, word_count}, 32'd17);

      // Reset in the middle of a word, then reset during HOLD.
      do_reset();
      send(8'h55, 1'b0, w);
      send(8'h66, 1'b0, w);
      do_reset();
      send(8'hA1, 1'b0, w);
      send(8'hA2, 1'b0, w);
      send(8'hA3, 1'b0, w);
      check("post_reset_word", out_port, 32'hB0A3_A2A1);
      step(1'b0, 8'h00, 1'b0);
      do_reset();
      send(8'hB1, 1'b1, w);
      check("post_hold_reset_word", out_port, 32'hD000_00B1);

      // A valid pulse during HOLD is ignored and the next word starts at slot 0.
      do_reset();
      send(8'h10, 1'b0, w);
      send(8'h20, 1'b0, w);
      send(8'h30, 1'b0, w);
      check("pulse_first_word", out_port, 32'hB030_2010);
      saved = out_port;
      step(1'b1, 8'h77, 1'b1);
      step(1'b0, 8'h00, 1'b0);
      check("pulse_out_stable", out_port, saved);
      send(8'h81, 1'b0, w);
      send(8'h82, 1'b0, w);
      send(8'h83, 1'b0, w);
      check("pulse_next_word", out_port, 32'h3183_8281);

      // Randomised traffic; a pending byte is held on the bus until it is accepted.
      do_reset();
      p_v = 1'b0;
      p_d = '0;
      p_l = 1'b0;
      for (int i = 0; i < 800; i++) begin
         if (!p_v) begin
            p_v = ($urandom_range(0, 3) != 0);
            p_d = 8'($urandom);
            p_l = ($urandom_range(0, 4) == 0);
         end
         step(p_v, p_d, p_l);
         if (m_acc) p_v = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/parallel_hps_single_pio_word_packer.md
PARALLEL_HPS_SINGLE_PIO_WORD_PACKER -- requirements
Module: parallel_hps_single_pio_word_packer

Interface
REQ-001 SHALL provide parameter HOLD_CYCLES, default 4, meaning minimum cycles each published word stays stable on out_port with in_ready low; legal range 2..255.
REQ-002 SHALL have port clk  input  1  sole clock, all state rising-edge.
REQ-003 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-004 SHALL have port in_data  input  8  byte from upstream source.
REQ-005 SHALL have port in_valid  input  1  in_data valid.
REQ-006 SHALL have port in_last  input  1  qualifies the byte as final of a burst, forcing a partial-word flush.
REQ-007 SHALL have port in_ready  output  1  block accepts a byte this cycle.
REQ-008 SHALL have port out_port  output  32  packed word driving the 32-bit input PIO in_port.
REQ-009 SHALL have port word_count  output  16  number of words published since reset.
REQ-010 SHALL use one clock; reset SHALL be asynchronous and active-high, ports named clk and reset.

Function
REQ-011 Byte accepted SHALL be on a rising clk edge with in_valid=1 and in_ready=1; no other condition accepts.
REQ-012 out_port format SHALL be: [31] toggle, [30] last, [29:28] valid byte count (1..3), [27:24] sequence number, [23:0] payload with byte0 in [7:0], byte1 in [15:8], byte2 in [23:16].
REQ-013 States SHALL be FILL and HOLD; FILL: in_ready=1; HOLD: in_ready=0.
REQ-014 In FILL a 2-bit slot index (0..2) SHALL select the payload byte written; it increments per accepted byte.
REQ-015 Word completes on the edge accepting slot 2, or accepting any byte with in_last=1.
REQ-016 On the completing edge out_port SHALL update (latency 1 cycle from acceptance): payload = collected bytes, unused upper bytes 0, count = bytes in word, last = in_last of completing byte, toggle inverted, sequence incremented.
REQ-017 Sequence SHALL wrap 15 -> 0; word_count SHALL wrap 65535 -> 0; both increment on each completing edge only.
REQ-018 On the completing edge slot index SHALL return to 0, partial buffer cleared, state -> HOLD, in_ready registered low.
REQ-019 in_ready SHALL stay low for exactly HOLD_CYCLES cycles and rise on the HOLD_CYCLES-th edge after the completing edge; state -> FILL at that edge.
REQ-020 out_port SHALL change only on completing edges; between them all 32 bits are stable, so the downstream PIO edge detector sees exactly one change event per word (bit 31 guarantees a change even for identical payloads).
REQ-021 in_valid during HOLD SHALL be ignored; source must hold in_data/in_valid/in_last until accepted.
REQ-022 in_last on slot 0 byte SHALL publish a 1-byte word (count=1, payload[23:8]=0).
REQ-023 Non-completing bytes SHALL not alter out_port.
REQ-024 in_ready SHALL be a register output, no combinational path from any input.

Reset
REQ-025 While reset=1: out_port=0, word_count=0, in_ready=0, state FILL, slot index 0, buffer 0, sequence 0, hold counter 0.
REQ-026 in_ready SHALL rise on the first clk edge after reset deasserts.
REQ-027 Reset asserted mid-word or mid-HOLD SHALL discard partial bytes immediately with no word published.

Verification
REQ-028 Reset, then bytes 0x11,0x22,0x33 back-to-back -> out_port=0xB0332211 one cycle after third acceptance (toggle 1, last 0, count 3, seq 0), word_count=1.
REQ-029 After REQ-028, byte 0x44 with in_last=1 at earliest ready -> out_port=0x51000044 (toggle 0, last 1, count 1, seq 1), word_count=2.
REQ-030 HOLD_CYCLES=4, in_valid held high continuously -> in_ready low exactly 4 cycles after each completing edge; no byte lost or duplicated.
REQ-031 Publish 17 identical words 0x00,0x00,0x00 -> sequence field wraps 15 -> 0 on word 17, bit 31 alternates every word, out_port changes exactly 17 times.
REQ-032 Accept 2 bytes, assert reset for 1 cycle -> out_port=0, in_ready=0 during reset, next 3 bytes form seq 0 word with no residual data.
REQ-033 in_valid pulsed during HOLD -> pulse ignored, out_port and slot index unchanged.
